menu_controller: RTL
====================

// Module: menu_controller
// PURPOSE
//   Sequences the game configuration menu before a round starts: MODO -> BPM -> TOM -> MUSICA.
//   Arrow pulses move a per-menu cursor; enter commits the cursor into a one-hot selection register.
//   Drives menu_sel/opcao to the display and Arduino, and the registra_* strobes to fluxo_dados.
//   Sits between unidade_controle (inicia_menu) and the fluxo_dados configuration registers.
// PARAMETERS
//   MODO    6   number of game modes (2..16)
//   BPM     2   number of tempo options (2..16)
//   TOM     4   number of key/transposition options (2..16)
//   MUSICA  16  number of songs (2..16)
// PORTS
//   clock                input   1       system clock; all state changes on rising edge
//   reset                input   1       synchronous, active-high
//   inicia_menu          input   1       1-cycle pulse: start (or restart) the menu sequence
//   right_arrow_pressed  input   1       1-cycle pulse, already debounced: cursor +1
//   left_arrow_pressed   input   1       1-cycle pulse, already debounced: cursor -1
//   enter_pressed        input   1       1-cycle pulse, already debounced: commit cursor
//   menu_sel             output  3       current menu: 0 IDLE, 1 MODO, 2 BPM, 3 TOM, 4 MUSICA, 5 DONE
//   mostra_menu          output  1       high in MODO/BPM/TOM/MUSICA
//   opcao                output  4       cursor index in the current menu; 0 outside menus
//   registra_modo        output  1       1-cycle strobe when the mode is committed
//   registra_bpm         output  1       1-cycle strobe when the BPM is committed
//   registra_tom         output  1       1-cycle strobe when the tom is committed
//   registra_musicas     output  1       1-cycle strobe when the song is committed
//   modos                output  MODO    one-hot committed mode
//   bpms                 output  BPM     one-hot committed BPM
//   toms                 output  TOM     one-hot committed tom
//   musicas              output  MUSICA  one-hot committed song
//   menu_pronto          output  1       1-cycle pulse: all four selections committed
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values:
//     - state IDLE; menu_sel=0; opcao=0.
//     - All strobes and menu_pronto low; mostra_menu low.
//     - modos/bpms/toms/musicas = one-hot bit 0 (default option).
//   - FSM transitions:
//     - IDLE -> MODO on inicia_menu.
//     - MODO -> BPM -> TOM -> MUSICA, each on enter_pressed.
//     - MUSICA -> DONE on enter_pressed.
//     - DONE -> IDLE unconditionally after 1 cycle.
//   - inicia_menu in any non-IDLE state (mid-menu restart):
//     - next state MODO, opcao=0.
//     - Already-committed selections are kept, not cleared.
//     - It overrides an enter, arrow or commit in the same cycle; no strobe fires.
//   - Cursor:
//     - Cleared to 0 on every menu entry.
//     - right: opcao=(opcao==N-1)?0:opcao+1.
//     - left:  opcao=(opcao==0)?N-1:opcao-1.
//     - N is the option count of the current menu (MODO/BPM/TOM/MUSICA).
//     - right and left in the same cycle: no cursor change.
//     - Arrows outside a menu state are ignored.
//   - Commit timing: enter in cycle t (menu state X, cursor c):
//     - At t+1: the selection for X = 1<<c and registra_X=1 for exactly that cycle.
//     - At t+1: menu_sel points to the next menu and opcao=0.
//     - enter takes priority over arrows in the same cycle; the value committed is c (pre-arrow).
//   - menu_pronto=1 for exactly the single cycle the FSM is in DONE (the cycle after the MUSICA commit).
//   - One commit per enter pulse; an enter held for consecutive cycles advances one menu per cycle.
//   - In IDLE/DONE, enter is ignored; the selection registers hold their value indefinitely.
//   - Selection registers are always exactly one-hot, including after reset.
// TESTING
//   - Reset, then hold idle: menu_sel=0, opcao=0, modos=6'b000001, musicas=16'h0001, all strobes 0.
//   - Full pass:
//     - inicia_menu, right x2, enter -> registra_modo pulse, modos=6'b000100, menu_sel=2.
//     - enter -> bpms=2'b01; left, enter -> toms=4'b1000.
//     - enter -> musicas=16'h0001; menu_pronto pulses 1 cycle after the MUSICA commit, then menu_sel=0.
//   - Wrap-around in MUSICA:
//     - left from 0 -> opcao=15; right -> opcao=0.
//     - right x16 from 0 -> opcao=0.
//   - Simultaneous inputs:
//     - left+right same cycle -> opcao unchanged.
//     - enter+right with opcao=1 in MODO -> modos=6'b000010 committed.
//   - Restart: in TOM with bpms=2'b10, pulse inicia_menu together with enter ->
//     menu_sel=1, opcao=0, no registra_tom, bpms stays 2'b10.
//   - Reset mid-menu, in BPM with opcao=1 -> next cycle IDLE, all selections back to one-hot bit 0.

Source files
------------

// File: rtl/menu_controller.sv
// ---------------------------------------------------------------------------
// menu_controller : pre-round config menu sequencer MODO->BPM->TOM->MUSICA
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module menu_controller #(
  parameter int MODO   = 6,
  parameter int BPM    = 2,
  parameter int TOM    = 4,
  parameter int MUSICA = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicia_menu,
  input  logic              right_arrow_pressed,
  input  logic              left_arrow_pressed,
  input  logic              enter_pressed,
  output logic [2:0]        menu_sel,
  output logic              mostra_menu,
  output logic [3:0]        opcao,
  output logic              registra_modo,
  output logic              registra_bpm,
  output logic              registra_tom,
  output logic              registra_musicas,
  output logic [MODO-1:0]   modos,
  output logic [BPM-1:0]    bpms,
  output logic [TOM-1:0]    toms,
  output logic [MUSICA-1:0] musicas,
  output logic              menu_pronto
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MODO   = 3'd1,
    S_BPM    = 3'd2,
    S_TOM    = 3'd3,
    S_MUSICA = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] MODO_LAST   = 4'(MODO - 1);
  localparam logic [3:0] BPM_LAST    = 4'(BPM - 1);
  localparam logic [3:0] TOM_LAST    = 4'(TOM - 1);
  localparam logic [3:0] MUSICA_LAST = 4'(MUSICA - 1);

  localparam logic [MODO-1:0]   MODO_DEF   = MODO'(1);
  localparam logic [BPM-1:0]    BPM_DEF    = BPM'(1);
  localparam logic [TOM-1:0]    TOM_DEF    = TOM'(1);
  localparam logic [MUSICA-1:0] MUSICA_DEF = MUSICA'(1);

  state_t            state_q, state_d;
  logic [3:0]        opcao_q, opcao_d;
  logic [3:0]        last_w;
  logic              mostra_q, mostra_d;
  logic              pronto_q, pronto_d;
  logic              reg_modo_q, reg_modo_d;
  logic              reg_bpm_q, reg_bpm_d;
  logic              reg_tom_q, reg_tom_d;
  logic              reg_mus_q, reg_mus_d;
  logic [MODO-1:0]   modos_q, modos_d;
  logic [BPM-1:0]    bpms_q, bpms_d;
  logic [TOM-1:0]    toms_q, toms_d;
  logic [MUSICA-1:0] musicas_q, musicas_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      opcao_q    <= 4'd0;
      mostra_q   <= 1'b0;
      pronto_q   <= 1'b0;
      reg_modo_q <= 1'b0;
      reg_bpm_q  <= 1'b0;
      reg_tom_q  <= 1'b0;
      reg_mus_q  <= 1'b0;
      modos_q    <= MODO_DEF;
      bpms_q     <= BPM_DEF;
      toms_q     <= TOM_DEF;
      musicas_q  <= MUSICA_DEF;
    end else begin
      state_q    <= state_d;
      opcao_q    <= opcao_d;
      mostra_q   <= mostra_d;
      pronto_q   <= pronto_d;
      reg_modo_q <= reg_modo_d;
      reg_bpm_q  <= reg_bpm_d;
      reg_tom_q  <= reg_tom_d;
      reg_mus_q  <= reg_mus_d;
      modos_q    <= modos_d;
      bpms_q     <= bpms_d;
      toms_q     <= toms_d;
      musicas_q  <= musicas_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcao_d    = opcao_q;
    reg_modo_d = 1'b0;
    reg_bpm_d  = 1'b0;
    reg_tom_d  = 1'b0;
    reg_mus_d  = 1'b0;
    modos_d    = modos_q;
    bpms_d     = bpms_q;
    toms_d     = toms_q;
    musicas_d  = musicas_q;

    case (state_q)
      S_MODO:   last_w = MODO_LAST;
      S_BPM:    last_w = BPM_LAST;
      S_TOM:    last_w = TOM_LAST;
      S_MUSICA: last_w = MUSICA_LAST;
      default:  last_w = 4'd0;
    endcase

    // A restart wins over everything else in the same cycle, so no strobe escapes.
    if (inicia_menu) begin
      state_d = S_MODO;
      opcao_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_MODO, S_BPM, S_TOM, S_MUSICA: begin
          if (enter_pressed) begin
            opcao_d = 4'd0;
            case (state_q)
              S_MODO: begin
                modos_d    = MODO_DEF << opcao_q;
                reg_modo_d = 1'b1;
                state_d    = S_BPM;
              end
              S_BPM: begin
                bpms_d    = BPM_DEF << opcao_q;
                reg_bpm_d = 1'b1;
                state_d   = S_TOM;
              end
              S_TOM: begin
                toms_d    = TOM_DEF << opcao_q;
                reg_tom_d = 1'b1;
                state_d   = S_MUSICA;
              end
              default: begin
                musicas_d = MUSICA_DEF << opcao_q;
                reg_mus_d = 1'b1;
                state_d   = S_DONE;
              end
            endcase
          end else if (right_arrow_pressed && !left_arrow_pressed) begin
            opcao_d = (opcao_q == last_w) ? 4'd0 : opcao_q + 4'd1;
          end else if (left_arrow_pressed && !right_arrow_pressed) begin
            opcao_d = (opcao_q == 4'd0) ? last_w : opcao_q - 4'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    mostra_d = (state_d == S_MODO) || (state_d == S_BPM) ||
               (state_d == S_TOM)  || (state_d == S_MUSICA);
    pronto_d = (state_d == S_DONE);
  end

  assign menu_sel         = state_q;
  assign mostra_menu      = mostra_q;
  assign opcao            = opcao_q;
  assign registra_modo    = reg_modo_q;
  assign registra_bpm     = reg_bpm_q;
  assign registra_tom     = reg_tom_q;
  assign registra_musicas = reg_mus_q;
  assign modos            = modos_q;
  assign bpms             = bpms_q;
  assign toms             = toms_q;
  assign musicas          = musicas_q;
  assign menu_pronto      = pronto_q;

endmodule

`default_nettype wire
